cpu_sequencer: RTL and testbench

- Parametrised microcode sequencer for the CPU core; successor to the fixed 8-bit-state control FSM.
- Owns the microcode state register, interrupt master enable (IME) with delayed EI, HALT, interrupt entry and a bounded micro-call stack.
- The microcode ROM decodes `state` into datapath controls. It feeds this block `ubranch`, `next_state` and `ime_update`. A decode ROM supplies the opcode dispatch target.

---
 rtl/cpu_seq_pkg.sv | 18 +
 rtl/cpu_irq_prio.sv | 28 ++
 rtl/cpu_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types for the microcode sequencer: microbranch ops, IME ops, state type.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_seq_pkg;

   localparam int STATE_W_DEF = 8;

   typedef logic [STATE_W_DEF-1:0] state_t;

   typedef enum logic [2:0] {
      Next, Jump, Cond, Dispatch, Prefix, Call, Ret, Halt
   } ubranch_e;

   typedef enum logic [1:0] {
      Same, Enable, EnableNow, Disable
   } ime_update_e;

endpackage

// File: rtl/cpu_irq_prio.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index, any-request flag.
// Latency: combinational.
// Backpressure: none.
module cpu_irq_prio #(
   parameter int N  = 5,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = |req_i;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            idx_o       = IW'(i);
         end
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Microcode sequencer: state register, IME with delayed EI, HALT, interrupt entry, micro-call stack.
// Latency: all state commits on the t_cycle==PHASES-1 edge; int_ack is a 1-clk pulse after entry.
// Backpressure: none; optional HALT-bug pulse output under macro CPU_SEQ_HALT_BUG_EN.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int                 STATE_W     = 8,
   parameter int                 PHASES      = 4,
   parameter int                 NUM_IRQ     = 5,
   parameter logic [STATE_W-1:0] INT_STATE   = 8'hF0,
   parameter int                 UCALL_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [$clog2(PHASES)-1:0]  t_cycle,
   input  logic                       condition,
   input  ubranch_e                   ubranch,
   input  logic [STATE_W-1:0]         next_state,
   input  ime_update_e                ime_update,
   input  logic [STATE_W-1:0]         dispatch_state,
   input  logic [NUM_IRQ-1:0]         irq_pending,
   output logic [STATE_W-1:0]         state,
   output logic                       dispatch_prefix,
   output logic                       ime,
   output logic                       halted,
   output logic [NUM_IRQ-1:0]         int_ack,
   output logic [$clog2(NUM_IRQ)-1:0] int_id,
`ifdef CPU_SEQ_HALT_BUG_EN
   output logic                       halt_bug,
`endif
   output logic                       useq_err
);

   localparam int TW    = $clog2(PHASES);
   localparam int IW    = $clog2(NUM_IRQ);
   localparam int SP_W  = $clog2(UCALL_DEPTH + 1);
   localparam int IDX_W = (UCALL_DEPTH > 1) ? $clog2(UCALL_DEPTH) : 1;

   logic [STATE_W-1:0] state_q, state_d;
   logic               ime_q, ime_d, ei_q, ei_d;
   logic               halted_q, halted_d, prefix_q, prefix_d, err_q, err_d;
   logic [NUM_IRQ-1:0] ack_q, ack_d;
   logic [IW-1:0]      id_q, id_d;
   logic [SP_W-1:0]    sp_q, sp_d;
   logic [STATE_W-1:0] stack_q [UCALL_DEPTH];
   logic               hb_q, hb_d;

   logic               commit, ime_eff, take_irq, push_en;
   logic [STATE_W-1:0] state_inc;
   logic [IDX_W-1:0]   push_idx, pop_idx;
   logic [NUM_IRQ-1:0] prio_onehot;
   logic [IW-1:0]      prio_idx;
   logic               prio_any;

   cpu_irq_prio #(.N(NUM_IRQ), .IW(IW)) u_prio (
      .req_i    (irq_pending),
      .onehot_o (prio_onehot),
      .idx_o    (prio_idx),
      .any_o    (prio_any)
   );

   assign commit    = (t_cycle == TW'(PHASES - 1));
   assign state_inc = state_q + STATE_W'(1);
   // A DI in the dispatching state wins over a pending or already-set IME.
   assign ime_eff   = (ime_q | ei_q) & (ime_update != Disable);
   assign push_idx  = IDX_W'(sp_q);
   assign pop_idx   = IDX_W'(sp_q - SP_W'(1));

   // Next-state: microbranch, IME op, halt exit and interrupt entry, all gated by commit.
   always_comb begin
      state_d  = state_q;
      ime_d    = ime_q;
      ei_d     = ei_q;
      halted_d = halted_q;
      prefix_d = prefix_q;
      err_d    = err_q;
      id_d     = id_q;
      sp_d     = sp_q;
      ack_d    = '0;
      hb_d     = 1'b0;
      take_irq = 1'b0;
      push_en  = 1'b0;
      if (commit) begin
         if (halted_q) begin
            // While halted the ROM ops are ignored; only a pending irq wakes us.
            if (prio_any) begin
               halted_d = 1'b0;
               if (ime_q) take_irq = 1'b1;
               else       state_d  = state_inc;
            end
         end else begin
            case (ubranch)
               Next:   state_d = state_inc;
               Jump:   state_d = next_state;
               Cond:   state_d = condition ? next_state : state_inc;
               Call: begin
                  state_d = next_state;
                  if (sp_q == SP_W'(UCALL_DEPTH)) begin
                     err_d = 1'b1;
                  end else begin
                     push_en = 1'b1;
                     sp_d    = sp_q + SP_W'(1);
                  end
               end
               Ret: begin
                  if (sp_q == '0) begin
                     state_d = '0;
                     err_d   = 1'b1;
                  end else begin
                     state_d = stack_q[pop_idx];
                     sp_d    = sp_q - SP_W'(1);
                  end
               end
               Prefix: begin
                  prefix_d = 1'b1;
                  state_d  = dispatch_state;
               end
               Dispatch: begin
                  if (ime_eff && prio_any) begin
                     take_irq = 1'b1;
                  end else begin
                     ime_d    = ime_eff;
                     ei_d     = 1'b0;
                     state_d  = dispatch_state;
                     prefix_d = 1'b0;
                  end
               end
               Halt: begin
`ifdef CPU_SEQ_HALT_BUG_EN
                  if (!ime_q && prio_any) begin
                     hb_d    = 1'b1;
                     state_d = state_inc;
                  end else begin
                     halted_d = 1'b1;
                  end
`else
                  halted_d = 1'b1;
`endif
               end
               default: ;
            endcase
            // The IME op of this state lands after the dispatch check, so an EI
            // in the dispatching state only arms ei_pending for the next one.
            if (!take_irq) begin
               case (ime_update)
                  Enable:    ei_d = 1'b1;
                  EnableNow: ime_d = 1'b1;
                  Disable: begin
                     ime_d = 1'b0;
                     ei_d  = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         if (take_irq) begin
            state_d  = INT_STATE;
            ime_d    = 1'b0;
            ei_d     = 1'b0;
            ack_d    = prio_onehot;
            id_d     = prio_idx;
            prefix_d = 1'b0;
            sp_d     = '0;
         end
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= '0;
         ime_q    <= 1'b0;
         ei_q     <= 1'b0;
         halted_q <= 1'b0;
         prefix_q <= 1'b0;
         err_q    <= 1'b0;
         id_q     <= '0;
         sp_q     <= '0;
         ack_q    <= '0;
         hb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ime_q    <= ime_d;
         ei_q     <= ei_d;
         halted_q <= halted_d;
         prefix_q <= prefix_d;
         err_q    <= err_d;
         id_q     <= id_d;
         sp_q     <= sp_d;
         ack_q    <= ack_d;
         hb_q     <= hb_d;
      end
   end

   // Return-address storage; validity is tracked by sp_q, so no reset needed.
   always_ff @(posedge clk) begin
      if (reset_n && push_en) stack_q[push_idx] <= state_inc;
   end

   assign state           = state_q;
   assign dispatch_prefix = prefix_q;
   assign ime             = ime_q;
   assign halted          = halted_q;
   assign int_ack         = ack_q;
   assign int_id          = id_q;
   assign useq_err        = err_q;
`ifdef CPU_SEQ_HALT_BUG_EN
   assign halt_bug        = hb_q;
`else
   logic unused_hb;
   assign unused_hb = hb_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed M-cycle scenarios plus random traffic.
// Expected outputs come from a behavioural model and are queued per clock;
// a separate monitor pops and compares on the falling edge.
module tb_cpu_sequencer;
   import cpu_seq_pkg::*;

   localparam int          PHASES      = 4;
   localparam int          UCALL_DEPTH = 2;
   localparam logic [7:0]  INT_STATE   = 8'hF0;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [1:0]  t_cycle;
   logic        condition;
   ubranch_e    ubranch;
   logic [7:0]  next_state;
   ime_update_e ime_update;
   logic [7:0]  dispatch_state;
   logic [4:0]  irq_pending;
   logic [7:0]  state;
   logic        dispatch_prefix, ime, halted, useq_err;
   logic [4:0]  int_ack;
   logic [2:0]  int_id;
   logic        hb_out;

   cpu_sequencer #(
      .STATE_W(8), .PHASES(PHASES), .NUM_IRQ(5),
      .INT_STATE(INT_STATE), .UCALL_DEPTH(UCALL_DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .t_cycle(t_cycle), .condition(condition),
      .ubranch(ubranch), .next_state(next_state), .ime_update(ime_update),
      .dispatch_state(dispatch_state), .irq_pending(irq_pending),
      .state(state), .dispatch_prefix(dispatch_prefix), .ime(ime),
      .halted(halted), .int_ack(int_ack), .int_id(int_id),
`ifdef CPU_SEQ_HALT_BUG_EN
      .halt_bug(hb_out),
`endif
      .useq_err(useq_err)
   );
`ifndef CPU_SEQ_HALT_BUG_EN
   assign hb_out = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] st;
      logic       pf, im, hl, er, hb;
      logic [4:0] ack;
      logic [2:0] id;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc = cyc + 1;

   // Reference model state, kept in plain integers and a queue for the stack.
   int m_state, m_id, m_ack;
   bit m_ime, m_ei, m_halt, m_pf, m_err, m_hb;
   int stk[$];

   task automatic model_step();
      bit take;
      bit eff;
      take  = 0;
      m_ack = 0;
      m_hb  = 0;
      if (!reset_n) begin
         m_state = 0; m_ime = 0; m_ei = 0; m_halt = 0; m_pf = 0; m_id = 0; m_err = 0;
         stk.delete();
      end else if (int'(t_cycle) == PHASES - 1) begin
         if (m_halt) begin
            if (irq_pending != 0) begin
               m_halt = 0;
               if (m_ime) take = 1;
               else       m_state = (m_state + 1) % 256;
            end
         end else begin
            case (ubranch)
               Next: m_state = (m_state + 1) % 256;
               Jump: m_state = int'(next_state);
               Cond: m_state = condition ? int'(next_state) : (m_state + 1) % 256;
               Call: begin
                  if (stk.size() < UCALL_DEPTH) stk.push_back((m_state + 1) % 256);
                  else m_err = 1;
                  m_state = int'(next_state);
               end
               Ret: begin
                  if (stk.size() == 0) begin m_state = 0; m_err = 1; end
                  else m_state = stk.pop_back();
               end
               Prefix: begin m_pf = 1; m_state = int'(dispatch_state); end
               Dispatch: begin
                  eff = (m_ime || m_ei) && (ime_update != Disable);
                  if (eff && irq_pending != 0) take = 1;
                  else begin
                     m_ime = eff; m_ei = 0; m_pf = 0;
                     m_state = int'(dispatch_state);
                  end
               end
               Halt: begin
`ifdef CPU_SEQ_HALT_BUG_EN
                  if (!m_ime && irq_pending != 0) begin
                     m_hb = 1; m_state = (m_state + 1) % 256;
                  end else m_halt = 1;
`else
                  m_halt = 1;
`endif
               end
               default: ;
            endcase
            if (!take) begin
               case (ime_update)
                  Enable:    m_ei = 1;
                  EnableNow: m_ime = 1;
                  Disable:   begin m_ime = 0; m_ei = 0; end
                  default: ;
               endcase
            end
         end
         if (take) begin
            int i;
            i = 0;
            while (!irq_pending[i]) i++;
            m_ack = 1 << i; m_id = i; m_state = int'(INT_STATE);
            m_ime = 0; m_ei = 0; m_pf = 0;
            stk.delete();
         end
      end
   endtask

   // Apply one clock of inputs, queue the model's view of the following edge.
   task automatic drive(input bit rst, input int t, input ubranch_e ub, input logic [7:0] ns,
                        input ime_update_e iu, input logic [7:0] ds, input logic [4:0] irq,
                        input bit cnd);
      exp_t e;
      reset_n = rst; t_cycle = 2'(t); ubranch = ub; next_state = ns;
      ime_update = iu; dispatch_state = ds; irq_pending = irq; condition = cnd;
      model_step();
      e.cyc = cyc + 1; e.st = 8'(m_state); e.pf = m_pf; e.im = m_ime; e.hl = m_halt;
      e.er = m_err; e.hb = m_hb; e.ack = 5'(m_ack); e.id = 3'(m_id);
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   function automatic ubranch_e rnd_ub();
      return ubranch_e'(3'($urandom_range(0, 7)));
   endfunction

   function automatic ime_update_e rnd_iu();
      return ime_update_e'(2'($urandom_range(0, 3)));
   endfunction

   // One M-cycle: non-commit phases carry junk ops that must be ignored.
   task automatic mcycle(input ubranch_e ub, input logic [7:0] ns, input ime_update_e iu,
                         input logic [7:0] ds, input logic [4:0] irq, input bit cnd);
      for (int p = 0; p < PHASES - 1; p++)
         drive(1, p, rnd_ub(), 8'($urandom), rnd_iu(), 8'($urandom), irq, 1'($urandom));
      drive(1, PHASES - 1, ub, ns, iu, ds, irq, cnd);
   endtask

   // Monitor: compare every clock whose expectation is due.
   exp_t me;
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         me = sb.pop_front();
         checks++;
         if (state === me.st && dispatch_prefix === me.pf && ime === me.im &&
             halted === me.hl && useq_err === me.er && int_ack === me.ack &&
             int_id === me.id && hb_out === me.hb) begin
            passed++;
         end else begin
            $display("FAIL outputs cyc=%0d got st=%h pf=%b ime=%b hlt=%b ack=%b id=%0d err=%b hb=%b need st=%h pf=%b ime=%b hlt=%b ack=%b id=%0d err=%b hb=%b",
                     cyc, state, dispatch_prefix, ime, halted, int_ack, int_id, useq_err, hb_out,
                     me.st, me.pf, me.im, me.hl, me.ack, me.id, me.er, me.hb);
         end
      end
   end

   initial begin
      reset_n = 0; t_cycle = 0; condition = 0; ubranch = Next; next_state = 0;
      ime_update = Same; dispatch_state = 0; irq_pending = 0;
      @(posedge clk); #1;
      drive(0, 0, Next, 0, Same, 0, 0, 0);
      drive(0, 3, Jump, 8'h55, EnableNow, 0, 0, 0);

      // Next x3: state steps only on commit edges.
      repeat (3) mcycle(Next, 0, Same, 0, 5'b00000, 0);

      // Delayed EI: first dispatch not serviced, second enters interrupt.
      mcycle(Dispatch, 0, Enable, 8'h10, 5'b00100, 0);
      mcycle(Dispatch, 0, Same, 8'h11, 5'b00100, 0);
      mcycle(Next, 0, Same, 0, 5'b00000, 0);

      // DI in the dispatching state blocks a pending irq.
      mcycle(Next, 0, EnableNow, 0, 5'b00000, 0);
      mcycle(Dispatch, 0, Disable, 8'h22, 5'b00001, 0);

      // HALT with ime=0, long idle, then wake without servicing.
      mcycle(Jump, 8'h30, Same, 0, 5'b00000, 0);
      repeat (11) mcycle(Halt, 0, Same, 0, 5'b00000, 0);
      mcycle(Halt, 0, Same, 0, 5'b10000, 0);
      mcycle(Next, 0, Same, 0, 5'b00000, 0);

      // HALT with ime=1 and a pending irq: enter, then wake into service.
      mcycle(Next, 0, EnableNow, 0, 5'b00000, 0);
      mcycle(Halt, 0, Same, 0, 5'b01010, 0);
      mcycle(Halt, 0, Same, 0, 5'b01010, 0);

      // Micro-call overflow and underflow.
      mcycle(Call, 8'h50, Same, 0, 0, 0);
      mcycle(Call, 8'h60, Same, 0, 0, 0);
      mcycle(Call, 8'h70, Same, 0, 0, 0);
      repeat (4) mcycle(Ret, 0, Same, 0, 0, 0);

      // CB prefix then normal dispatch; wrap of state+1 and Cond both ways.
      mcycle(Prefix, 0, Same, 8'h40, 0, 0);
      mcycle(Dispatch, 0, Same, 8'h41, 0, 0);
      mcycle(Jump, 8'hFF, Same, 0, 0, 0);
      mcycle(Next, 0, Same, 0, 0, 0);
      mcycle(Cond, 8'h77, Same, 0, 0, 1);
      mcycle(Cond, 8'h99, Same, 0, 0, 0);

      // Reset in the middle of an M-cycle, straight after an interrupt entry.
      mcycle(Next, 0, EnableNow, 0, 0, 0);
      drive(1, 0, Next, 0, Same, 0, 5'b00011, 0);
      drive(1, 1, Next, 0, Same, 0, 5'b00011, 0);
      drive(1, 2, Next, 0, Same, 0, 5'b00011, 0);
      drive(1, 3, Dispatch, 0, Same, 8'h12, 5'b00011, 0);
      drive(0, 0, Next, 0, Same, 0, 5'b00011, 0);
      mcycle(Next, 0, Same, 0, 0, 0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0)
            drive(0, int'($urandom_range(0, 3)), rnd_ub(), 8'($urandom), rnd_iu(), 8'($urandom), 5'($urandom), 1'($urandom));
         mcycle(rnd_ub(), 8'($urandom), rnd_iu(), 8'($urandom),
                ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000, 1'($urandom));
      end

      @(negedge clk); #1;
      checks++;
      if (sb.size() == 0) passed++;
      else $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
